register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  - 32 x 32-bit general-purpose register file for the single-cycle/pipelined MIPS datapath.
//  - Two combinational read ports (rs->A, rt->B) feed the ALU operands; one synchronous write port (rd/dataIn/we) is driven by writeback.
//  - Register 0 is hardwired to zero per the MIPS ISA.
// PARAMETERS
//  - DATA_W  32  register/data width in bits
//  - ADDR_W  5   register address width
//  - NREGS   32  number of registers (= 2**ADDR_W)
// PORTS
//  - clk     in   1       single clock; all state updates on rising edge
//  - rst     in   1       reset; synchronous, active-high
//  - we      in   1       write enable for port rd
//  - rs      in   ADDR_W  read address, port A
//  - rt      in   ADDR_W  read address, port B
//  - rd      in   ADDR_W  write address
//  - dataIn  in   DATA_W  write data
//  - A       out  DATA_W  contents of register rs
//  - B       out  DATA_W  contents of register rt
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset:
//    - On a rising clk edge with rst=1, all NREGS registers clear to 0.
//    - rst has priority over we; the write is discarded.
//    - After that edge, A=B=0 for every address.
//    - Before the first reset edge, contents are undefined (X in sim).
//    - Reset asserted mid-operation clears everything at the next edge, regardless of pending writes.
//  - Write:
//    - On a rising clk edge with rst=0 and we=1, reg[rd] <= dataIn.
//    - we=0 leaves all registers unchanged.
//    - Single-cycle latency: data is visible on A/B from the edge onward.
//  - Register 0:
//    - Writes with rd=0 are ignored.
//    - A and B always read 0 when their address is 0, including before any reset.
//  - Read:
//    - Purely combinational; A=reg[rs], B=reg[rt].
//    - No clock latency; outputs change within the same cycle as the address changes.
//    - rs==rt is legal; A and B then carry identical values.
//  - Write/read collision (rd==rs or rd==rt, we=1, same cycle): see CONFIGURATION.
//    - Without the macro, the read returns the old value until the edge.
//  - No handshake and no error conditions.
//    - Addresses wrap naturally within ADDR_W bits; there are no out-of-range cases.
// CONFIGURATION
//  - Macro REGFILE_WRITE_BYPASS_EN.
//  - Defined:
//    - When we=1, rst=0, rd!=0 and rd==rs, A is driven by dataIn combinationally in the same cycle; likewise B when rd==rt.
//    - Removes the write-then-read hazard for the pipelined core.
//  - Undefined: no forwarding path; reads return the stored value (old until the edge).
//  - Register 0 stays zero in both builds.
// STRUCTURE
//  - Package regfile_pkg holds:
//    - DATA_W, ADDR_W, NREGS defaults
//    - constant REG_ZERO = 5'd0
//    - typedef reg_addr_t (logic [ADDR_W-1:0])
//    - typedef reg_data_t (logic [DATA_W-1:0])
//  - Sub-module register_file_read_port:
//    - Combinational address decode, zero-forcing for r0, optional bypass mux.
//    - Instantiated twice (A and B).
//  - Storage array and write logic live in the top.
// TESTING
//  - Reset: rst=1 for one edge with we=1, rd=1, dataIn=32'h1002aaff -> afterwards A/B read 0 for all rs/rt 0..31.
//  - Write/read: rst=0, we=1, rd=1, dataIn=32'h1002aaff, one edge; then rs=1 -> A=32'h1002aaff.
//    - Sweep rd 1..31 with dataIn incremented by 32'hB9 each cycle; read back all values on both A and B.
//  - R0: we=1, rd=0, dataIn=32'hFFFFFFFF -> rs=0 gives A=0 and rt=0 gives B=0.
//  - Hold: we=0, rd=5, dataIn=32'hDEADBEEF, several edges -> reg5 keeps its prior value.
//  - Reset mid-run: after reg1..reg31 are loaded, assert rst with we=1 -> next edge all read 0; the write is lost.
//  - Collision: we=1, rd=rs=7, dataIn=32'h12345678, reg7=32'hAAAA0000 before the edge.
//    - With REGFILE_WRITE_BYPASS_EN: A=32'h12345678 before the edge.
//    - Without it: A=32'hAAAA0000 before the edge, 32'h12345678 after.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the MIPS general-purpose register file.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file: array select, r0 forced
// to zero, and (when REGFILE_WRITE_BYPASS_EN is defined) forwarding of the
// write-port data when the write address matches this port's address.
module register_file_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic [DATA_W-1:0] i_regs [NREGS],
  input  logic [ADDR_W-1:0] i_addr,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
`endif
  output logic [DATA_W-1:0] o_data
);

  // Select stored word, optionally forward in-flight write, then force r0 to zero.
  always_comb begin
    o_data = i_regs[i_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (i_wr_en && (i_wr_addr != REG_ZERO) && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
`endif
    if (i_addr == REG_ZERO) begin
      o_data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports (A from rs,
// B from rt), one synchronous write port, r0 hardwired to zero.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN forwards the write data to a
// read port whose address matches rd in the same cycle.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  logic [DATA_W-1:0] r_regs [NREGS];

`ifdef REGFILE_WRITE_BYPASS_EN
  // A write only lands (and so may only be forwarded) when reset is not pending.
  logic w_wr_en;
  assign w_wr_en = we && !rst;
`endif

  // Storage update: reset clears every entry and beats any write; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && (rd != REG_ZERO)) begin
      r_regs[rd] <= dataIn;
    end
  end

  register_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_port_a (
    .i_regs    (r_regs),
    .i_addr    (rs),
`ifdef REGFILE_WRITE_BYPASS_EN
    .i_wr_en   (w_wr_en),
    .i_wr_addr (rd),
    .i_wr_data (dataIn),
`endif
    .o_data    (A)
  );

  register_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_port_b (
    .i_regs    (r_regs),
    .i_addr    (rt),
`ifdef REGFILE_WRITE_BYPASS_EN
    .i_wr_en   (w_wr_en),
    .i_wr_addr (rd),
    .i_wr_data (dataIn),
`endif
    .o_data    (B)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, write/read sweep, mid-run
// reset, then random traffic against an array-based reference model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] dataIn;
  logic [31:0] A;
  logic [31:0] B;

  int nvec = 0;
  int nmis = 0;

  register_file dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .dataIn (dataIn),
    .A      (A),
    .B      (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  localparam logic [31:0] COLL_A = 32'h12345678;
`else
  localparam bit BYPASS = 1'b0;
  localparam logic [31:0] COLL_A = 32'hAAAA0000;
`endif

  vec_t tbl [14];

  // Reference model: plain array of register contents.
  logic [31:0] model [32];

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic r,
                                             input logic w, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && w && !r && wa == a) return wd;
    return model[a];
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [4:0] wa,
                            input logic [31:0] wd);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; we = w; rd = wa; dataIn = wd; rs = a; rt = b;
    #1;
  endtask

  logic [31:0] v;
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  initial begin
    rst = 1'b0; we = 1'b0; rd = '0; rs = '0; rt = '0; dataIn = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Expected values are the pre-edge reads for the inputs on the same row.
    tbl[0]  = '{1'b1, 1'b1, 5'd1, 32'h1002aaff, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd1, 32'h1002aaff, 5'd2, 5'd3, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 5'd1, 32'h0,        5'd1, 5'd1, 32'h1002aaff, 32'h1002aaff};
    tbl[3]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 32'h0, 32'h1002aaff};
    tbl[5]  = '{1'b0, 1'b1, 5'd5, 32'h55555555, 5'd1, 5'd0, 32'h1002aaff, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'h55555555, 32'h55555555};
    tbl[7]  = '{1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'h55555555, 32'h55555555};
    tbl[8]  = '{1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'h55555555, 32'h55555555};
    tbl[9]  = '{1'b0, 1'b1, 5'd7, 32'hAAAA0000, 5'd5, 5'd1, 32'h55555555, 32'h1002aaff};
    tbl[10] = '{1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, COLL_A, COLL_A};
    tbl[11] = '{1'b0, 1'b0, 5'd7, 32'h0,        5'd7, 5'd5, 32'h12345678, 32'h55555555};
    tbl[12] = '{1'b1, 1'b1, 5'd9, 32'h00000099, 5'd7, 5'd9, 32'h12345678, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 5'd9, 32'h0,        5'd7, 5'd9, 32'h0, 32'h0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].rd, tbl[i].din, tbl[i].rs, tbl[i].rt);
      check($sformatf("tbl%0d_A", i), A, tbl[i].ea);
      check($sformatf("tbl%0d_B", i), B, tbl[i].eb);
      model_edge(tbl[i].rst, tbl[i].we, tbl[i].rd, tbl[i].din);
    end

    // Sweep writes rd 1..31 with data stepping by 0xB9.
    v = 32'h1002aaff;
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), v, 5'd0, 5'd0);
      model_edge(1'b0, 1'b1, 5'(i), v);
      v = v + 32'hB9;
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      check($sformatf("sweepA_r%0d", i), A, 32'h1002aaff + 32'(i - 1) * 32'hB9);
      check($sformatf("sweepB_r%0d", 32 - i), B, 32'h1002aaff + 32'(31 - i) * 32'hB9);
    end

    // Reset mid-run with a competing write to r3: write is lost, all clear.
    drive(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd31);
    check("rst_pre_A", A, 32'h1002aaff + 32'd2 * 32'hB9);
    check("rst_pre_B", B, 32'h1002aaff + 32'd30 * 32'hB9);
    model_edge(1'b1, 1'b1, 5'd3, 32'hCAFEF00D);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check($sformatf("rst_post_A%0d", i), A, 32'h0);
      check($sformatf("rst_post_B%0d", 31 - i), B, 32'h0);
    end

    // Collision after edge: reg7 preload, colliding write, then read back.
    drive(1'b0, 1'b1, 5'd7, 32'hAAAA0000, 5'd0, 5'd0);
    model_edge(1'b0, 1'b1, 5'd7, 32'hAAAA0000);
    drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0);
    check("coll_pre_A", A, COLL_A);
    model_edge(1'b0, 1'b1, 5'd7, 32'h12345678);
    drive(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    check("coll_post_A", A, 32'h12345678);
    check("coll_post_B", B, 32'h12345678);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r, w;
      logic [4:0]  wa, a, b;
      logic [31:0] wd;
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      b  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, w, wa, wd, a, b);
      exp_a = model_read(a, r, w, wa, wd);
      exp_b = model_read(b, r, w, wa, wd);
      check($sformatf("rnd%0d_A", n), A, exp_a);
      check($sformatf("rnd%0d_B", n), B, exp_b);
      model_edge(r, w, wa, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
